// File: rtl/interrupt_controller.sv
// Interrupt front-end for the single-cycle MIPS core: synchronises three lines,
// latches rising edges, applies mask and fixed priority, and tracks one handler via IDLE/SERVICE.
module interrupt_controller #(
    parameter logic [31:0] ENTRY1 = 32'h0000_0000,
    parameter logic [31:0] ENTRY2 = 32'h0000_0000,
    parameter logic [31:0] ENTRY3 = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    input  logic        mask_we,
    input  logic [2:0]  mask_din,
    input  logic [31:0] pc_next,
    input  logic        irq_ack,
    input  logic        eret,
    output logic        irq_req,
    output logic [31:0] irq_vector,
    output logic [31:0] epc,
    output logic [2:0]  cause,
    output logic        in_service,
    output logic [2:0]  pending,
    output logic [2:0]  mask
);
    // Handshake: irq_req is offered only in IDLE; the core takes it by raising
    // irq_ack in the same cycle (accept = irq_ack & irq_req). SERVICE ends on eret.
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] SERVICE = 1'b1;

    logic [0:0] state;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] hist;
    logic [2:0] edges;
    logic [2:0] eligible;
    logic [2:0] winner;
    logic [2:0] clr;
    logic       accept;

    assign edges      = sync2 & ~hist;
    assign eligible   = pending & ~mask;
    assign in_service = (state == SERVICE);
    assign irq_req    = (state == IDLE) && (|eligible);
    assign accept     = irq_ack & irq_req;
    assign clr        = accept ? winner : 3'b000;

    always_comb begin
        winner     = 3'b000;
        irq_vector = ENTRY3;
        if (eligible[2]) begin
            winner     = 3'b100;
            irq_vector = ENTRY1;
        end else if (eligible[1]) begin
            winner     = 3'b010;
            irq_vector = ENTRY2;
        end else if (eligible[0]) begin
            winner     = 3'b001;
            irq_vector = ENTRY3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            hist  <= 3'b000;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // A fresh edge in the accept cycle wins over the clear so it is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 3'b000;
        end else begin
            pending <= (pending & ~clr) | edges;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= 3'b000;
        end else if (mask_we) begin
            mask <= mask_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            epc   <= 32'h0;
            cause <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        epc   <= pc_next;
                        cause <= winner;
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        cause <= 3'b000;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Upstream interrupt front-end for the single-cycle MIPS core.
- Synchronises three external interrupt lines, latches their rising edges as pending requests, and applies a mask and fixed priority.
- Presents one request with its entrance address to the core, and holds EPC and cause for the handler.
- Replaces the core's ad-hoc interrupt latches and CP0 disable flag with a proper IDLE/SERVICE handshake that ends with eret.

Parameters:
- ENTRY1, 32'h0000_0000, entrance address for source 2 (highest priority)
- ENTRY2, 32'h0000_0000, entrance address for source 1
- ENTRY3, 32'h0000_0000, entrance address for source 0 (lowest priority)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- irq_in  in  3  asynchronous external interrupt lines; bit 2 is highest priority
- mask_we  in  1  write strobe for the mask register
- mask_din  in  3  new mask value; bit=1 blocks the source
- pc_next  in  32  the core's next-PC value, captured into EPC on accept
- irq_ack  in  1  core has redirected the PC to irq_vector this cycle
- eret  in  1  handler finished; return to IDLE
- irq_req  out  1  interrupt request to the core
- irq_vector  out  32  entrance address of the winning source
- epc  out  32  saved return address
- cause  out  3  one-hot ID of the source in service
- in_service  out  1  high while in SERVICE state
- pending  out  3  raw pending bits, for status and debug
- mask  out  3  current mask register

Behaviour:
- Reset (async, rst=1): sync stages, edge history, pending, mask, epc, cause all clear to 0; state=IDLE. Every output reads 0; irq_vector reads ENTRY3 as the don't-care default.
- Synchronisation: per bit, a two-flop synchroniser s1→s2, plus history h<=s2. Edge = s2 & ~h.
- A line high at reset release counts as an edge.
- A pulse must span at least one posedge to be captured.
- Latency: irq_in rising before posedge N gives s1 at N, s2 at N+1 and pending at N+2, so irq_req is high after posedge N+2 if eligible.
- Pending: set by edge, cleared only on accept of that source. If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Further edges on a bit that is already pending are merged into it (no count).
- Mask: mask<=mask_din on mask_we, effective the next cycle. Masked sources keep their pending bit and fire once unmasked.
- eligible = pending & ~mask. Winner is the highest set bit of eligible (2>1>0).
- irq_vector = ENTRY1/ENTRY2/ENTRY3 for winner 2/1/0. It is combinational from registers.
- irq_req = (state==IDLE) & |eligible. It is combinational from registers.
- FSM IDLE:
  - irq_ack & irq_req → epc<=pc_next, cause<=one-hot winner, pending[winner] cleared, state→SERVICE.
  - irq_ack without irq_req is ignored.
  - eret in IDLE is ignored.
- FSM SERVICE:
  - irq_req=0 and in_service=1. Edges keep accumulating in pending.
  - eret → state=IDLE and cause<=0; epc is held.
  - irq_ack is ignored.
  - If eligible is nonzero, irq_req rises in the first IDLE cycle, i.e. the cycle after eret.
- Simultaneous mask_we and irq_ack: the accept uses the old mask.
- Simultaneous eret and a new edge: both take effect.
- No nesting: one EPC, so the global disable lasts until eret.
- rst asserted mid-SERVICE: immediate return to IDLE, and all pending requests are lost.

Test Plan:
- Reset then single edge: irq_in=3'b001 raised before posedge 5 → irq_req=1 after posedge 7 with irq_vector=ENTRY3. Ack with pc_next=32'h40 → epc=32'h40, cause=3'b001, in_service=1, pending=0.
- Priority: irq_in 3'b101 raised together → winner is bit 2 (vector ENTRY1). After eret, irq_req returns next cycle with vector ENTRY3 and pending=3'b001.
- Masking: mask=3'b100, then edge on bit 2 → irq_req stays 0 and pending=3'b100. Write mask=0 → irq_req=1 the following cycle.
- Service blocking: edge on bit 1 during SERVICE → irq_req=0 until eret, then 1. A second ack during SERVICE changes neither epc nor cause.
- Set/clear collision: new edge on bit 0 in the ack cycle for bit 0 → pending[0] stays 1 after accept.
- Async reset mid-SERVICE: rst pulsed between edges → all outputs 0 immediately (before the next posedge), state IDLE.
